// File: rtl/fnv_pkg.sv
// Shared constants, multiply shift table and FSM state type for the FNV-1a 32-bit hash core.
package fnv_pkg;

    localparam logic [31:0] FNV32_PRIME = 32'h01000193;
    localparam logic [31:0] FNV32_BASIS = 32'h811C9DC5;

    localparam int unsigned FNV_TERMS = 6;
    localparam logic [2:0]  FNV_LAST_TERM = 3'd5;

    // The prime is 2^24 + 2^8 + 2^7 + 2^4 + 2^1 + 2^0; one entry per set bit.
    localparam logic [4:0] FNV_SHIFT [0:5] = '{5'd0, 5'd1, 5'd4, 5'd7, 5'd8, 5'd24};

    typedef enum logic {
        IDLE = 1'b0,
        MUL  = 1'b1
    } state_t;

    function automatic logic [4:0] fnv_shift(input logic [2:0] idx);
        if (idx < 3'd6) begin
            return FNV_SHIFT[idx];
        end
        return 5'd0;
    endfunction

endpackage

// File: rtl/fnv_term_adder.sv
// Adds one shifted copy of the multiplicand (one set bit of the FNV prime) to a running sum.
module fnv_term_adder
    import fnv_pkg::*;
(
    input  logic [31:0] acc,
    input  logic [31:0] base,
    input  logic [2:0]  idx,
    output logic [31:0] sum
);

    logic [31:0] term;

    assign term = base << fnv_shift(idx);
    assign sum  = acc + term;

endmodule

// File: rtl/fnv1a_hash_core.sv
// FNV-1a 32-bit hash engine fed by a byte valid/ready stream.
// Define FNV_SERIAL_MUL_EN for a one-term-per-cycle multiplier; otherwise the multiply is single-cycle.
module fnv1a_hash_core
    import fnv_pkg::*;
#(
    parameter int          CNT_W = 16,
    parameter logic [31:0] BASIS = FNV32_BASIS
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             in_valid,
    input  logic [7:0]       in_data,
    output logic             in_ready,
    output logic [31:0]      digest,
    output logic [CNT_W-1:0] byte_count,
    output logic             busy
);

    logic [31:0]      digest_q;
    logic [CNT_W-1:0] count_q;
    logic             accept;

    assign accept     = in_valid & in_ready;
    assign digest     = digest_q;
    assign byte_count = count_q;

`ifdef FNV_SERIAL_MUL_EN

    state_t      state_q, state_d;
    logic [2:0]  term_q;
    logic [31:0] base_q;
    logic [31:0] prod_q;
    logic [31:0] prod_sum;

    fnv_term_adder u_term_adder (
        .acc  (prod_q),
        .base (base_q),
        .idx  (term_q),
        .sum  (prod_sum)
    );

    always_comb begin
        state_d  = state_q;
        in_ready = 1'b0;
        busy     = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = ~clear;
                if (in_valid && !clear) begin
                    state_d = MUL;
                end
            end
            MUL: begin
                busy = 1'b1;
                if (term_q == FNV_LAST_TERM) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (clear) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            term_q   <= 3'd0;
            base_q   <= 32'h0;
            prod_q   <= 32'h0;
            digest_q <= BASIS;
            count_q  <= '0;
        end else if (clear) begin
            // Any partial product is dropped; the digest restarts from the basis.
            state_q  <= IDLE;
            term_q   <= 3'd0;
            prod_q   <= 32'h0;
            digest_q <= BASIS;
            count_q  <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                base_q  <= digest_q ^ {24'h0, in_data};
                prod_q  <= 32'h0;
                term_q  <= 3'd0;
                count_q <= count_q + 1'b1;
            end else if (state_q == MUL) begin
                prod_q <= prod_sum;
                term_q <= term_q + 3'd1;
                if (term_q == FNV_LAST_TERM) begin
                    digest_q <= prod_sum;
                end
            end
        end
    end

`else

    logic [31:0] mix;
    logic [31:0] chain [0:6];

    assign mix      = digest_q ^ {24'h0, in_data};
    assign chain[0] = 32'h0;
    assign in_ready = ~clear;
    assign busy     = 1'b0;

    for (genvar k = 0; k < 6; k++) begin : g_term
        fnv_term_adder u_term_adder (
            .acc  (chain[k]),
            .base (mix),
            .idx  (3'(k)),
            .sum  (chain[k+1])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digest_q <= BASIS;
            count_q  <= '0;
        end else if (clear) begin
            digest_q <= BASIS;
            count_q  <= '0;
        end else if (accept) begin
            digest_q <= chain[6];
            count_q  <= count_q + 1'b1;
        end
    end

`endif

endmodule
